// File: rtl/tpa_dual_port_regfile.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tpa_dual_port_regfile: register array shared by a cfg port and a serial   |
// | SCL/SDA slave. Option macro: TPA_FRAME_PARITY_EN.  Revision: 1.0          |
// +--------------------------------------------------------------------------+
module tpa_dual_port_regfile #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int CFG_WINS = 1,
  parameter int TA_BITS  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCL,
  inout  wire               SDA,
  input  logic              cfg_req,
  input  logic              cfg_cmd,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic              cfg_rdy,
  output logic [DATA_W-1:0] cfg_rdata,
  output logic              tw_busy,
  output logic              tw_perr
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(DATA_W + ADDR_W + TA_BITS + 1);
  localparam bit CFG_PRIO = (CFG_WINS != 0);

  typedef enum logic [3:0] {
    TW_IDLE, TW_CMD, TW_ADDR, TW_WDATA, TW_WPAR,
    TW_TA, TW_RSTART, TW_RDATA, TW_RPAR
  } tw_state_e;

  typedef enum logic {C_IDLE, C_ACK} cfg_state_e;

  logic [DATA_W-1:0] mem_q [DEPTH];

  cfg_state_e        cfg_state_q, cfg_state_d;
  logic [DATA_W-1:0] cfg_rdata_q, cfg_rdata_d;
  logic              cfg_we;

  tw_state_e         tw_state_q, tw_state_d;
  logic              scl_prev_q;
  logic              tw_cmd_q, tw_cmd_d;
  logic [ADDR_W-1:0] tw_addr_q, tw_addr_d;
  logic [DATA_W-1:0] tw_data_q, tw_data_d;
  logic [CNT_W-1:0]  tw_cnt_q, tw_cnt_d;
  logic              sda_oe_q, sda_oe_d;
  logic              sda_out_q, sda_out_d;
  logic              tw_perr_q, tw_perr_d;
  logic              tw_we;
`ifdef TPA_FRAME_PARITY_EN
  logic              tw_par_q, tw_par_d;
`endif

  logic sda_in;
  logic bit_tick;
  logic same_addr;
  logic tw_commit;
  logic cfg_commit;

  assign SDA      = sda_oe_q ? sda_out_q : 1'bz;
  assign sda_in   = SDA;
  assign bit_tick = SCL & ~scl_prev_q;

  // Cfg port: access happens on the accepting edge, C_ACK is the rdy cycle.
  always_comb begin
    cfg_state_d = cfg_state_q;
    cfg_rdata_d = cfg_rdata_q;
    cfg_we      = 1'b0;
    case (cfg_state_q)
      C_IDLE: begin
        if (cfg_req) begin
          cfg_state_d = C_ACK;
          if (cfg_cmd) cfg_we = 1'b1;
          else         cfg_rdata_d = mem_q[cfg_addr];
        end
      end
      default: cfg_state_d = C_IDLE;
    endcase
  end

  always_comb begin
    tw_state_d = tw_state_q;
    tw_cmd_d   = tw_cmd_q;
    tw_addr_d  = tw_addr_q;
    tw_data_d  = tw_data_q;
    tw_cnt_d   = tw_cnt_q;
    sda_oe_d   = sda_oe_q;
    sda_out_d  = sda_out_q;
    tw_perr_d  = 1'b0;
    tw_we      = 1'b0;
`ifdef TPA_FRAME_PARITY_EN
    tw_par_d   = tw_par_q;
`endif
    if (bit_tick) begin
      case (tw_state_q)
        TW_IDLE: begin
          if (!sda_in) tw_state_d = TW_CMD;
        end
        TW_CMD: begin
          tw_cmd_d   = sda_in;
          tw_cnt_d   = '0;
          tw_state_d = TW_ADDR;
`ifdef TPA_FRAME_PARITY_EN
          tw_par_d   = sda_in;
`endif
        end
        TW_ADDR: begin
          tw_addr_d = {sda_in, tw_addr_q[ADDR_W-1:1]};
          tw_cnt_d  = tw_cnt_q + CNT_W'(1);
`ifdef TPA_FRAME_PARITY_EN
          tw_par_d  = tw_par_q ^ sda_in;
`endif
          if (tw_cnt_q == CNT_W'(ADDR_W - 1)) begin
            tw_cnt_d = '0;
            if (tw_cmd_q) begin
              tw_state_d = TW_WDATA;
            end else begin
              // Sampled here, so a same-edge write is not seen (read-before-write).
              tw_data_d  = mem_q[tw_addr_d];
              tw_state_d = TW_TA;
            end
          end
        end
        TW_WDATA: begin
          tw_data_d = {sda_in, tw_data_q[DATA_W-1:1]};
          tw_cnt_d  = tw_cnt_q + CNT_W'(1);
`ifdef TPA_FRAME_PARITY_EN
          tw_par_d  = tw_par_q ^ sda_in;
`endif
          if (tw_cnt_q == CNT_W'(DATA_W - 1)) begin
            tw_cnt_d = '0;
`ifdef TPA_FRAME_PARITY_EN
            tw_state_d = TW_WPAR;
`else
            tw_we      = 1'b1;
            tw_state_d = TW_IDLE;
`endif
          end
        end
`ifdef TPA_FRAME_PARITY_EN
        TW_WPAR: begin
          tw_state_d = TW_IDLE;
          if (tw_par_q != sda_in) tw_perr_d = 1'b1;
          else                    tw_we     = 1'b1;
        end
`endif
        TW_TA: begin
          tw_cnt_d = tw_cnt_q + CNT_W'(1);
          if (tw_cnt_q == CNT_W'(TA_BITS - 1)) begin
            sda_oe_d   = 1'b1;
            sda_out_d  = 1'b1;
            tw_cnt_d   = '0;
            tw_state_d = TW_RSTART;
          end
        end
        TW_RSTART: begin
          sda_oe_d   = 1'b1;
          sda_out_d  = 1'b0;
          tw_cnt_d   = '0;
          tw_state_d = TW_RDATA;
`ifdef TPA_FRAME_PARITY_EN
          tw_par_d   = 1'b0;
`endif
        end
        TW_RDATA: begin
          if (tw_cnt_q == CNT_W'(DATA_W)) begin
`ifdef TPA_FRAME_PARITY_EN
            sda_out_d  = tw_par_q;
            tw_state_d = TW_RPAR;
`else
            sda_oe_d   = 1'b0;
            tw_state_d = TW_IDLE;
`endif
          end else begin
            sda_out_d = tw_data_q[0];
            tw_data_d = tw_data_q >> 1;
            tw_cnt_d  = tw_cnt_q + CNT_W'(1);
`ifdef TPA_FRAME_PARITY_EN
            tw_par_d  = tw_par_q ^ tw_data_q[0];
`endif
          end
        end
`ifdef TPA_FRAME_PARITY_EN
        TW_RPAR: begin
          sda_oe_d   = 1'b0;
          tw_state_d = TW_IDLE;
        end
`endif
        default: begin
          sda_oe_d   = 1'b0;
          tw_state_d = TW_IDLE;
        end
      endcase
    end
  end

  assign same_addr  = tw_we && cfg_we && (tw_addr_q == cfg_addr);
  assign tw_commit  = tw_we && !(same_addr && CFG_PRIO);
  assign cfg_commit = cfg_we && !(same_addr && !CFG_PRIO);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (tw_commit)  mem_q[tw_addr_q] <= tw_data_d;
      if (cfg_commit) mem_q[cfg_addr]  <= cfg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_state_q <= C_IDLE;
      cfg_rdata_q <= '0;
      tw_state_q  <= TW_IDLE;
      scl_prev_q  <= 1'b1;  // no phantom bit-time if SCL is high out of reset
      tw_cmd_q    <= 1'b0;
      tw_addr_q   <= '0;
      tw_data_q   <= '0;
      tw_cnt_q    <= '0;
      sda_oe_q    <= 1'b0;
      sda_out_q   <= 1'b0;
      tw_perr_q   <= 1'b0;
`ifdef TPA_FRAME_PARITY_EN
      tw_par_q    <= 1'b0;
`endif
    end else begin
      cfg_state_q <= cfg_state_d;
      cfg_rdata_q <= cfg_rdata_d;
      tw_state_q  <= tw_state_d;
      scl_prev_q  <= SCL;
      tw_cmd_q    <= tw_cmd_d;
      tw_addr_q   <= tw_addr_d;
      tw_data_q   <= tw_data_d;
      tw_cnt_q    <= tw_cnt_d;
      sda_oe_q    <= sda_oe_d;
      sda_out_q   <= sda_out_d;
      tw_perr_q   <= tw_perr_d;
`ifdef TPA_FRAME_PARITY_EN
      tw_par_q    <= tw_par_d;
`endif
    end
  end

  assign cfg_rdy   = (cfg_state_q == C_ACK);
  assign cfg_rdata = cfg_rdata_q;
  assign tw_busy   = (tw_state_q != TW_IDLE);
  assign tw_perr   = tw_perr_q;

endmodule
`default_nettype wire
